spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of rate, interval and window values.
REQ-002 Port clk  input  1: single clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1: reset, synchronous, active-low.
REQ-004 Port ena  input  1: decoder enable; low aborts any window in progress.
REQ-005 Port spike_in  input  1: spike stream from the neuron, one spike per high cycle.
REQ-006 Port window_len  input  WIDTH: window length in cycles; value 0 means 2^WIDTH.
REQ-007 Port rate_out  output  WIDTH: spike count of the last completed window.
REQ-008 Port rate_valid  output  1: one-cycle pulse, rate_out updated this cycle.
REQ-009 Port rate_sat  output  1: last reported window saturated its count.
REQ-010 Port isi_out  output  WIDTH: cycles between the last two spikes.
REQ-011 Port isi_valid  output  1: one-cycle pulse, isi_out updated this cycle.

Function
REQ-012 FSM states SHALL be IDLE, COUNT and REPORT.
REQ-013 IDLE -> COUNT when ena=1; window_len sampled into the window counter on that transition.
REQ-014 window_len changes after sampling SHALL have no effect until the next window start.
REQ-015 In COUNT, a cycle with spike_in=1 SHALL increment spike_cnt, saturating at 2^WIDTH-1 and setting a sticky sat bit.
REQ-016 In COUNT, the window counter SHALL decrement each cycle; on the cycle it equals 1, that cycle's spike is counted and the FSM goes to REPORT.
REQ-017 In REPORT (one cycle), rate_out <= spike_cnt, rate_sat <= sat bit, rate_valid=1.
REQ-018 Window latency: rate_valid SHALL assert exactly one cycle after the last window cycle.
REQ-019 A spike arriving in the REPORT cycle SHALL be counted in the next window (no spike lost, none double-counted).
REQ-020 REPORT -> COUNT with window_len re-sampled if ena=1; otherwise REPORT -> IDLE.
REQ-021 ena=0 in COUNT SHALL return to IDLE next cycle, clear spike_cnt and sat, emit no rate_valid, and leave rate_out unchanged.
REQ-022 The ISI timer SHALL count cycles since the last spike, saturating at 2^WIDTH-1, independent of FSM state while ena=1.
REQ-023 On a spike with a previous spike recorded, isi_out <= timer value +1 (adjacent spikes give 1) and isi_valid=1 the next cycle; timer restarts.
REQ-024 The first spike after reset or after ena falls SHALL only arm the timer and emit no isi_valid.
REQ-025 ena=0 SHALL disarm the ISI timer; isi_out holds its value.
REQ-026 rate_valid and isi_valid SHALL be independent and may assert in the same cycle.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 at a clock edge SHALL put the FSM in IDLE and clear rate_out, rate_sat, rate_valid, isi_out, isi_valid, spike_cnt, sat, window counter and the ISI timer, including mid-window.
REQ-029 The first window after reset release SHALL start in the cycle after ena is first sampled high.

Structure
REQ-030 A shared package mvm_pkg SHALL hold WIDTH default, the FSM state enumeration and the window-length-zero encoding constant.
REQ-031 The ISI logic SHALL be a sub-module isi_timer (clk, rst_n, ena, spike_in -> isi_out, isi_valid).
REQ-032 The window counter, spike counter and FSM SHALL live in spike_rate_decoder itself.

Verification
REQ-033 window_len=10, ena=1, spike_in high every 2nd cycle -> rate_valid every 11 cycles, rate_out=5, rate_sat=0.
REQ-034 window_len=0, spike_in held high -> rate_valid after 257 cycles, rate_out=255, rate_sat=1.
REQ-035 window_len=4, spike only in REPORT cycle -> current window rate_out unaffected, next window rate_out=1.
REQ-036 window_len=20, ena dropped at cycle 7 -> no rate_valid, rate_out keeps previous value; restart yields full 20-cycle window.
REQ-037 Spikes at cycles 3, 4, 10 -> isi_valid twice, isi_out=1 then 6; no isi_valid after the first spike.
REQ-038 rst_n low mid-window with 3 spikes counted -> all outputs 0 next cycle, FSM IDLE, following window counts from 0.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the spike-rate decoder slice.
//   WIDTH_DEF  : default width of rate / interval / window values
//   state_e    : window FSM states
//   WLEN_ZERO  : window_len encoding that stands for a full 2^WIDTH window
package mvm_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int WLEN_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;
endpackage

// File: rtl/isi_timer.sv
// Inter-spike-interval timer.
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : enable; low disarms the timer (isi_out holds)
//   spike_in   : spike stream
//   isi_out    : cycles between the last two spikes (adjacent spikes = 1)
//   isi_valid  : one-cycle pulse when isi_out is updated
module isi_timer
  import mvm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  output logic [WIDTH-1:0] isi_out,
  output logic             isi_valid
);

  logic [WIDTH-1:0] timer_q;
  logic             armed_q;
  logic [WIDTH-1:0] isi_q;
  logic             isi_vld_q;
  logic [WIDTH:0]   gap_p1;
  logic [WIDTH-1:0] isi_d;

  // Interval is timer+1; a saturated timer reports the maximum value.
  assign gap_p1 = {1'b0, timer_q} + 1'b1;
  assign isi_d  = gap_p1[WIDTH] ? '1 : gap_p1[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      armed_q   <= 1'b0;
      isi_q     <= '0;
      isi_vld_q <= 1'b0;
    end else begin
      isi_vld_q <= 1'b0;
      if (!ena) begin
        armed_q <= 1'b0;
        timer_q <= '0;
      end else if (spike_in) begin
        // First spike after disarm only arms the timer.
        if (armed_q) begin
          isi_q     <= isi_d;
          isi_vld_q <= 1'b1;
        end
        armed_q <= 1'b1;
        timer_q <= '0;
      end else if (!(&timer_q)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign isi_out   = isi_q;
  assign isi_valid = isi_vld_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder with inter-spike-interval output.
//   clk, rst_n  : clock, synchronous active-low reset
//   ena         : enable; low aborts a window in progress
//   spike_in    : spike stream, one spike per high cycle
//   window_len  : window length in cycles (0 = 2^WIDTH), sampled at window start
//   rate_out    : spike count of the last completed window
//   rate_valid  : one-cycle pulse when rate_out is updated
//   rate_sat    : last reported window overflowed its count
//   isi_out     : cycles between the last two spikes
//   isi_valid   : one-cycle pulse when isi_out is updated
module spike_rate_decoder
  import mvm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIDTH-1:0] window_len,
  output logic [WIDTH-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [WIDTH-1:0] isi_out,
  output logic             isi_valid
);

  state_e           state_q;
  logic [WIDTH:0]   win_q;     // one extra bit so a full 2^WIDTH window fits
  logic [WIDTH-1:0] cnt_q;
  logic             sat_q;
  logic [WIDTH-1:0] rate_q;
  logic             rate_sat_q;
  logic             rate_vld_q;

  logic [WIDTH:0]   win_load_d;
  logic [WIDTH-1:0] cnt_d;
  logic             sat_d;

  assign win_load_d = (window_len == WIDTH'(WLEN_ZERO)) ? {1'b1, {WIDTH{1'b0}}}
                                                        : {1'b0, window_len};

  // Saturating spike count; sat latches when a spike would overflow.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (spike_in) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      rate_q     <= '0;
      rate_sat_q <= 1'b0;
      rate_vld_q <= 1'b0;
    end else begin
      rate_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          sat_q <= 1'b0;
          if (ena) begin
            win_q   <= win_load_d;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!ena) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (win_q == (WIDTH+1)'(1)) begin
              // Result is registered on entry so it is visible during REPORT.
              state_q    <= ST_REPORT;
              win_q      <= '0;
              rate_q     <= cnt_d;
              rate_sat_q <= sat_d;
              rate_vld_q <= 1'b1;
            end else begin
              win_q <= win_q - 1'b1;
            end
          end
        end
        ST_REPORT: begin
          // The REPORT-cycle spike seeds the next window's count.
          sat_q <= 1'b0;
          cnt_q <= WIDTH'(ena & spike_in);
          if (ena) begin
            win_q   <= win_load_d;
            state_q <= ST_COUNT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rate_out   = rate_q;
  assign rate_sat   = rate_sat_q;
  assign rate_valid = rate_vld_q;

  isi_timer #(.WIDTH(WIDTH)) u_isi (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .isi_out   (isi_out),
    .isi_valid (isi_valid)
  );

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic [7:0] rate_out;
  logic       rate_valid;
  logic       rate_sat;
  logic [7:0] isi_out;
  logic       isi_valid;

  spike_rate_decoder #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_sat   (rate_sat),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int rate; bit sat; } rexp_t;
  typedef struct { int cyc; int isi; } iexp_t;
  rexp_t rq[$];
  iexp_t iq[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Reference model: true (unbounded) counts, clamped only when reported.
  // m_left: -1 = no window, 0 = report cycle, >0 = window cycles remaining.
  int m_left = -1;
  int m_cnt = 0;
  bit m_armed = 0;
  int m_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic void model(bit e, bit s, int wl, bit r);
    int len;
    len = (wl == 0) ? 256 : wl;
    if (!r) begin
      m_left = -1; m_cnt = 0; m_armed = 0; m_gap = 0;
      return;
    end
    if (m_left < 0) begin
      if (e) begin m_left = len; m_cnt = 0; end
    end else if (m_left == 0) begin
      if (e) begin m_left = len; m_cnt = s; end
      else begin m_left = -1; m_cnt = 0; end
    end else if (!e) begin
      m_left = -1; m_cnt = 0;
    end else begin
      m_cnt += s;
      m_left--;
      if (m_left == 0)
        rq.push_back('{cyc + 1, (m_cnt > 255) ? 255 : m_cnt, m_cnt > 255});
    end
    if (!e) begin
      m_armed = 0; m_gap = 0;
    end else if (s) begin
      if (m_armed) iq.push_back('{cyc + 1, (m_gap + 1 > 255) ? 255 : m_gap + 1});
      m_armed = 1; m_gap = 0;
    end else begin
      m_gap++;
    end
  endfunction

  task automatic step(input bit e, input bit s, input int wl, input bit r);
    @(negedge clk); #1;
    rst_n = r; ena = e; spike_in = s; window_len = 8'(wl);
    model(e, s, wl, r);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rate_out"}, 32'(rate_out), 0);
    chk({tag, "_rate_sat"}, 32'(rate_sat), 0);
    chk({tag, "_rate_valid"}, 32'(rate_valid), 0);
    chk({tag, "_isi_out"}, 32'(isi_out), 0);
    chk({tag, "_isi_valid"}, 32'(isi_valid), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a valid.
  initial begin
    forever begin
      @(negedge clk);
      while (rq.size() != 0 && rq[0].cyc < cyc) begin
        chk("rate_valid_missing", 0, 1);
        void'(rq.pop_front());
      end
      while (iq.size() != 0 && iq[0].cyc < cyc) begin
        chk("isi_valid_missing", 0, 1);
        void'(iq.pop_front());
      end
      if (rate_valid) begin
        if (rq.size() != 0 && rq[0].cyc == cyc) begin
          chk("rate_out", 32'(rate_out), 32'(rq[0].rate));
          chk("rate_sat", 32'(rate_sat), 32'(rq[0].sat));
          void'(rq.pop_front());
        end else chk("rate_valid_unexpected", 1, 0);
      end
      if (isi_valid) begin
        if (iq.size() != 0 && iq[0].cyc == cyc) begin
          chk("isi_out", 32'(isi_out), 32'(iq[0].isi));
          void'(iq.pop_front());
        end else chk("isi_valid_unexpected", 1, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dens, wl;
    // Reset state
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    settle();
    chk_all_zero("reset");

    // Period-2 spikes, 10-cycle windows
    for (int i = 0; i < 36; i++) step(1, (i % 2) == 0, 10, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 10, 1);

    // Spike only in the REPORT cycle
    for (int i = 0; i < 14; i++) step(1, m_left == 0, 4, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 4, 1);

    // Full 256-cycle window, spike held high
    for (int i = 0; i < 260; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
    settle();
    chk("sat_window_rate", 32'(rate_out), 255);
    chk("sat_window_sat", 32'(rate_sat), 1);

    // Abort mid-window, then a clean restart; window_len changes mid-window
    for (int i = 0; i < 8; i++) step(1, 1, 20, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 20, 1);
    settle();
    chk("abort_rate_held", 32'(rate_out), 255);
    chk("abort_sat_held", 32'(rate_sat), 1);
    for (int i = 0; i < 22; i++) step(1, 1, (i == 0) ? 20 : 3, 1);
    settle();
    chk("restart_rate", 32'(rate_out), 20);
    chk("restart_sat", 32'(rate_sat), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // ISI: spikes at relative cycles 3, 4, 10
    for (int i = 0; i < 15; i++) step(1, i == 3 || i == 4 || i == 10, 100, 1);
    settle();
    chk("isi_last", 32'(isi_out), 6);

    // Reset mid-window with 3 spikes counted
    step(0, 0, 10, 1);
    for (int i = 0; i < 6; i++) step(1, i >= 1 && i <= 3, 10, 1);
    step(1, 1, 10, 0);
    settle();
    chk_all_zero("midreset");
    for (int i = 0; i < 8; i++) step(1, i == 2, 4, 1);
    settle();
    chk("post_reset_rate", 32'(rate_out), 1);

    // Randomized traffic
    dens = 50;
    wl = 5;
    for (int i = 0; i < 3000; i++) begin
      bit e, s, r;
      if (i % 200 == 0) begin
        case ($urandom_range(0, 4))
          0: dens = 0;
          1: dens = 20;
          2: dens = 50;
          3: dens = 90;
          default: dens = 100;
        endcase
      end
      if ($urandom_range(0, 7) == 0)
        wl = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 12);
      e = ($urandom_range(0, 49) != 0);
      s = ($urandom_range(0, 99) < dens);
      r = ($urandom_range(0, 399) != 0);
      step(e, s, wl, r);
    end

    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    settle();
    chk("rate_queue_drained", 32'(rq.size()), 0);
    chk("isi_queue_drained", 32'(iq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
